// File: rtl/load_access_unit_pkg.sv
// Local types and decode helpers for the sequential load path.
package load_access_unit_pkg;
  import riscv_defines::*;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RSP  = 2'd2
  } lau_state_e;

  typedef struct packed {
    logic [31:0]            data;
    logic [4:0]             rd;
    logic                   fault;
    logic [CAUSE_WIDTH-1:0] cause;
  } load_rsp_t;

  function automatic logic load_op_legal(input logic [LOAD_OP_WIDTH-1:0] op);
    return (op == LOAD_OP_LB) || (op == LOAD_OP_LH) || (op == LOAD_OP_LW) ||
           (op == LOAD_OP_LBU) || (op == LOAD_OP_LHU);
  endfunction

  function automatic logic load_misaligned(input logic [LOAD_OP_WIDTH-1:0] op,
                                           input logic [1:0] addr_lo);
    return (((op == LOAD_OP_LH) || (op == LOAD_OP_LHU)) && addr_lo[0]) ||
           ((op == LOAD_OP_LW) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/riscv_defines.sv
// Shared core-wide encodings: load/store operation codes and trap causes.
package riscv_defines;

  localparam int unsigned LOAD_OP_WIDTH  = 3;
  localparam int unsigned STORE_OP_WIDTH = 2;
  localparam int unsigned CAUSE_WIDTH    = 4;

  // Load codes follow funct3 so the decoder can pass them straight through
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'd0;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'd1;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'd2;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'd4;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'd5;

  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'd0;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'd1;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'd2;

  localparam logic [CAUSE_WIDTH-1:0] CAUSE_ILLEGAL_INSN      = 4'd2;
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_LOAD_MISALIGNED   = 4'd4;
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_LOAD_ACCESS_FAULT = 4'd5;

endpackage

// File: rtl/load_access_unit_if.sv
// Request, data-memory and response channels of the load access unit.
interface load_access_unit_if;
  import riscv_defines::*;

  logic                     req_valid;
  logic                     req_ready;
  logic [31:0]              req_addr;
  logic [LOAD_OP_WIDTH-1:0] req_loadop;
  logic [4:0]               req_rd;

  logic                     mem_valid;
  logic                     mem_ready;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_rdata;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_data;
  logic [4:0]               rsp_rd;
  logic                     rsp_fault;
  logic [CAUSE_WIDTH-1:0]   rsp_cause;

  modport slave (
    input  req_valid, req_addr, req_loadop, req_rd, mem_ready, mem_rdata, rsp_ready,
    output req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_fault, rsp_cause
  );

  modport master (
    output req_valid, req_addr, req_loadop, req_rd, mem_ready, mem_rdata, rsp_ready,
    input  req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_fault, rsp_cause
  );

endinterface

// File: rtl/load_access_unit_load_extract.sv
// Selects the addressed byte/halfword of a read word and sign/zero extends it.
module load_extract
  import riscv_defines::*;
(
  input  logic [1:0]               addr_lo,
  input  logic [LOAD_OP_WIDTH-1:0] loadop,
  input  logic [31:0]              word,
  output logic [31:0]              data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    data_c = '0;
    case (loadop)
      LOAD_OP_LB:  data_c = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_LBU: data_c = {24'd0, byte_sel};
      LOAD_OP_LH:  data_c = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_LHU: data_c = {16'd0, half_sel};
      LOAD_OP_LW:  data_c = word;
      default:     data_c = '0;
    endcase
  end

endmodule

// File: rtl/load_access_unit.sv
// One-outstanding load path: alignment check, word read with watchdog, extend, respond.
module load_access_unit
  import riscv_defines::*;
  import load_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                resetn,
  load_access_unit_if.slave  bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lau_state_e               state_q, state_d;
  logic [1:0]               addr_lo_q, addr_lo_d;
  logic [LOAD_OP_WIDTH-1:0] op_q, op_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     req_ready_q, req_ready_d;
  logic                     mem_valid_q, mem_valid_d;
  logic [31:0]              mem_addr_q, mem_addr_d;
  logic                     rsp_valid_q, rsp_valid_d;
  load_rsp_t                rsp_q, rsp_d;

  logic        req_fire_c;
  logic        req_bad_op_c;
  logic        req_misaligned_c;
  logic        timeout_c;
  logic [31:0] extract_data_c;

  load_extract u_extract (
    .addr_lo (addr_lo_q),
    .loadop  (op_q),
    .word    (bus.mem_rdata),
    .data_c  (extract_data_c)
  );

  assign req_fire_c       = bus.req_valid && req_ready_q;
  assign req_bad_op_c     = !load_op_legal(bus.req_loadop);
  assign req_misaligned_c = load_misaligned(bus.req_loadop, bus.req_addr[1:0]);
  assign timeout_c        = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_fire_c) state_d = (req_bad_op_c || req_misaligned_c) ? ST_RSP : ST_MEM;
      ST_MEM:  if (bus.mem_ready || timeout_c) state_d = ST_RSP;
      ST_RSP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags follow the next state; payload registers update on their events
  always_comb begin
    addr_lo_d   = addr_lo_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    rsp_d       = rsp_q;
    req_ready_d = (state_d == ST_IDLE);
    mem_valid_d = (state_d == ST_MEM);
    rsp_valid_d = (state_d == ST_RSP);

    case (state_q)
      ST_IDLE: begin
        if (req_fire_c) begin
          addr_lo_d = bus.req_addr[1:0];
          op_d      = bus.req_loadop;
          rsp_d.rd  = bus.req_rd;
          if (req_bad_op_c) begin
            rsp_d.data  = '0;
            rsp_d.fault = 1'b1;
            rsp_d.cause = CAUSE_ILLEGAL_INSN;
          end else if (req_misaligned_c) begin
            rsp_d.data  = '0;
            rsp_d.fault = 1'b1;
            rsp_d.cause = CAUSE_LOAD_MISALIGNED;
          end else begin
            mem_addr_d = {bus.req_addr[31:2], 2'b00};
            cnt_d      = '0;
          end
        end
      end
      ST_MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_ready) begin
          rsp_d.data  = extract_data_c;
          rsp_d.fault = 1'b0;
          rsp_d.cause = '0;
        end else if (timeout_c) begin
          rsp_d.data  = '0;
          rsp_d.fault = 1'b1;
          rsp_d.cause = CAUSE_LOAD_ACCESS_FAULT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_lo_q   <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      addr_lo_q   <= addr_lo_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_rd    = rsp_q.rd;
  assign bus.rsp_fault = rsp_q.fault;
  assign bus.rsp_cause = rsp_q.cause;

endmodule

// File: tb/tb_load_access_unit.sv
// Scoreboard bench for load_access_unit with a 4-cycle memory watchdog.
module tb_load_access_unit;
  import riscv_defines::*;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  load_access_unit_if bus();

  load_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
    logic [3:0]  cause;
    int          rsp_cyc;
    int          mem_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference extraction: shift the addressed lane down, then extend
  function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] a,
                                        input logic [31:0] w);
    logic [31:0] s;
    s = w >> (32'(a) * 8);
    case (op)
      LOAD_OP_LB:  return {{24{s[7]}}, s[7:0]};
      LOAD_OP_LBU: return {24'd0, s[7:0]};
      LOAD_OP_LH:  return {{16{s[15]}}, s[15:0]};
      LOAD_OP_LHU: return {16'd0, s[15:0]};
      LOAD_OP_LW:  return w;
      default:     return 32'd0;
    endcase
  endfunction

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] op,
                          input logic [4:0] rd, input logic [31:0] word, input int lat,
                          input int hold, input logic exp_fault, input logic [3:0] exp_cause,
                          input int exp_rsp_cyc, input int exp_mem_cyc);
    exp_t e;
    int cyc;
    int mcnt;
    logic [31:0] aligned;
    e.data    = exp_fault ? 32'd0 : model(op, addr[1:0], word);
    e.rd      = rd;
    e.fault   = exp_fault;
    e.cause   = exp_cause;
    e.rsp_cyc = exp_rsp_cyc;
    e.mem_cyc = exp_mem_cyc;
    aligned   = {addr[31:2], 2'b00};

    check_eq({tag, "_req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_loadop = op;
    bus.req_rd     = rd;
    bus.mem_rdata  = word;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    sb.push_back(e);

    cyc  = 1;
    mcnt = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      check_eq({tag, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);
      if (bus.mem_valid) begin
        check_eq({tag, "_mem_addr"}, bus.mem_addr, aligned);
        bus.mem_ready = (mcnt == lat);
        mcnt++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.mem_ready = 1'b0;
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);

    e = sb.pop_front();
    check_eq({tag, "_rsp_cycle"}, 32'(cyc), 32'(e.rsp_cyc));
    check_eq({tag, "_mem_cycles"}, 32'(mcnt), 32'(e.mem_cyc));

    for (int h = 0; h <= hold; h++) begin
      check_eq({tag, "_rsp_data"}, bus.rsp_data, e.data);
      check_eq({tag, "_rsp_rd"}, 32'(bus.rsp_rd), 32'(e.rd));
      check_eq({tag, "_rsp_fault"}, 32'(bus.rsp_fault), 32'(e.fault));
      check_eq({tag, "_rsp_cause"}, 32'(bus.rsp_cause), 32'(e.cause));
      check_eq({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
      check_eq({tag, "_hold_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check_eq({tag, "_hold_mem_valid"}, 32'(bus.mem_valid), 32'd0);
      if (h == hold) bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    check_eq({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_req_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  ops [5];
    logic [2:0]  op;
    logic [31:0] addr;
    int          lat;

    ops = '{LOAD_OP_LB, LOAD_OP_LH, LOAD_OP_LW, LOAD_OP_LBU, LOAD_OP_LHU};
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_loadop = '0;
    bus.req_rd     = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
    check_eq("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check_eq("rst_rsp_cause", 32'(bus.rsp_cause), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_load("lb",  32'h1003, LOAD_OP_LB,  5'd1, 32'h8899AABB, 0, 0, 1'b0, 4'd0, 2, 1);
    run_load("lbu", 32'h1001, LOAD_OP_LBU, 5'd2, 32'h8899AABB, 0, 0, 1'b0, 4'd0, 2, 1);
    run_load("lh",  32'h1002, LOAD_OP_LH,  5'd3, 32'h8899AABB, 0, 0, 1'b0, 4'd0, 2, 1);
    run_load("lhu", 32'h1000, LOAD_OP_LHU, 5'd4, 32'h8899AABB, 0, 0, 1'b0, 4'd0, 2, 1);
    run_load("lw",  32'h1000, LOAD_OP_LW,  5'd5, 32'h8899AABB, 0, 0, 1'b0, 4'd0, 2, 1);

    run_load("lw_mis", 32'h1002, LOAD_OP_LW,  5'd7, 32'h8899AABB, 0, 0, 1'b1, 4'd4, 1, 0);
    run_load("lh_mis", 32'h1001, LOAD_OP_LHU, 5'd8, 32'h8899AABB, 0, 0, 1'b1, 4'd4, 1, 0);

    run_load("tmo",      32'h3000, LOAD_OP_LW, 5'd9,  32'h12345678, 100, 0, 1'b1, 4'd5, 5, TO);
    run_load("tmo_edge", 32'h3004, LOAD_OP_LW, 5'd10, 32'h12345678, TO - 1, 0, 1'b0, 4'd0, 5, TO);

    run_load("hold", 32'h1002, LOAD_OP_LBU, 5'd11, 32'h8899AABB, 0, 3, 1'b0, 4'd0, 2, 1);

    run_load("bad_op",  32'h1000, 3'b011, 5'd12, 32'h8899AABB, 0, 0, 1'b1, 4'd2, 1, 0);
    run_load("bad_op7", 32'h1001, 3'b111, 5'd13, 32'h8899AABB, 0, 0, 1'b1, 4'd2, 1, 0);

    // Abandon an in-flight read with an asynchronous reset
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h2000;
    bus.req_loadop = LOAD_OP_LW;
    bus.req_rd     = 5'd14;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("arst_pre_mem_valid", 32'(bus.mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("arst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("arst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("arst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check_eq("arst_no_mem", 32'(bus.mem_valid), 32'd0);
      check_eq("arst_idle_ready", 32'(bus.req_ready), 32'd1);
    end

    for (int i = 0; i < 8; i++) begin
      op   = ops[$urandom_range(0, 4)];
      addr = $urandom;
      if (op == LOAD_OP_LH || op == LOAD_OP_LHU) addr[0] = 1'b0;
      if (op == LOAD_OP_LW) addr[1:0] = 2'b00;
      lat = int'($urandom_range(0, 2));
      run_load("rand", addr, op, 5'($urandom), $urandom, lat, int'($urandom_range(0, 2)),
               1'b0, 4'd0, lat + 2, lat + 1);
    end

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
